// File: rtl/card_dealer.sv
// Shared card dealer for the blackjack table.
// Round-robin shoe arbiter with card handshake and table statistics.
module card_dealer #(
  parameter int NUM_PLAYERS = 4,
  parameter int CNT_W       = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NUM_PLAYERS-1:0] request_card,
  input  logic [NUM_PLAYERS-1:0] win,
  input  logic [NUM_PLAYERS-1:0] lost,
  output logic [NUM_PLAYERS-1:0] card_rdy,
  output logic [3:0]             card_value,
  input  logic                   shoe_valid,
  input  logic [3:0]             shoe_card,
  output logic                   shoe_pop,
  output logic [2:0]             grant_id,
  output logic                   busy,
  output logic [CNT_W-1:0]       hands_won,
  output logic [CNT_W-1:0]       hands_lost,
  output logic [CNT_W-1:0]       bad_cards
);

  localparam int IW = (NUM_PLAYERS > 4) ? 3 :
                      (NUM_PLAYERS > 2) ? 2 : 1;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DEAL,
    ACK
  } state_e;

  state_e                 state_q;
  logic [NUM_PLAYERS-1:0] rdy_q;
  logic [3:0]             value_q;
  logic [2:0]             grant_q;
  logic [IW-1:0]          last_q;
  logic                   busy_q;
  logic [CNT_W-1:0]       won_q;
  logic [CNT_W-1:0]       lost_q;
  logic [CNT_W-1:0]       bad_q;

  logic [IW-1:0]          gidx;
  logic [IW-1:0]          pick_id;
  logic [IW:0]            idx;
  logic                   pick_vld;
  logic                   card_ok;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

  assign gidx    = grant_q[IW-1:0];
  assign card_ok = (shoe_card != 4'd0) &&
                   (shoe_card <= 4'd10);

  // The pop is the only output allowed to follow shoe_valid directly;
  // a withdrawn request suppresses it.
  assign shoe_pop = (state_q == FETCH) &&
                    request_card[gidx] &&
                    shoe_valid;

  assign card_rdy   = rdy_q;
  assign card_value = value_q;
  assign grant_id   = grant_q;
  assign busy       = busy_q;
  assign hands_won  = won_q;
  assign hands_lost = lost_q;
  assign bad_cards  = bad_q;

  // Round-robin pick, starting one past the last granted player.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    idx      = '0;
    for (int i = 1; i <= NUM_PLAYERS; i++) begin
      idx = {1'b0, last_q} + (IW+1)'(i);
      if (idx >= (IW+1)'(NUM_PLAYERS))
        idx = idx - (IW+1)'(NUM_PLAYERS);
      if (!pick_vld && request_card[idx[IW-1:0]]) begin
        pick_vld = 1'b1;
        pick_id  = idx[IW-1:0];
      end
    end
  end

  // Dealer FSM with registered outputs and statistics.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rdy_q   <= '0;
      value_q <= '0;
      grant_q <= '0;
      last_q  <= IW'(NUM_PLAYERS-1);
      busy_q  <= 1'b0;
      won_q   <= '0;
      lost_q  <= '0;
      bad_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            grant_q <= 3'(pick_id);
            last_q  <= pick_id;
            busy_q  <= 1'b1;
            if (win[pick_id] || lost[pick_id]) begin
              state_q <= ACK;
              rdy_q   <= NUM_PLAYERS'(1) << pick_id;
              if (lost[pick_id])
                lost_q <= sat_inc(lost_q);
              else
                won_q <= sat_inc(won_q);
            end else begin
              state_q <= FETCH;
            end
          end
        end
        FETCH: begin
          if (!request_card[gidx]) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (shoe_valid) begin
            if (card_ok) begin
              value_q <= shoe_card;
              rdy_q   <= NUM_PLAYERS'(1) << gidx;
              state_q <= DEAL;
            end else begin
              bad_q <= sat_inc(bad_q);
            end
          end
        end
        DEAL: begin
          if (!request_card[gidx]) begin
            rdy_q   <= '0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        ACK: begin
          if (!win[gidx] && !lost[gidx]) begin
            rdy_q   <= '0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          rdy_q   <= '0;
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer.
// Each task drives one scenario and checks hand-computed values.
module tb_card_dealer;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] request_card = '0;
  logic [3:0] win = '0;
  logic [3:0] lost = '0;
  logic [3:0] card_rdy;
  logic [3:0] card_value;
  logic       shoe_valid = 1'b0;
  logic [3:0] shoe_card = '0;
  logic       shoe_pop;
  logic [2:0] grant_id;
  logic       busy;
  logic [7:0] hands_won;
  logic [7:0] hands_lost;
  logic [7:0] bad_cards;

  int checks = 0;
  int errs   = 0;

  card_dealer #(.NUM_PLAYERS(4), .CNT_W(8)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .request_card(request_card),
    .win         (win),
    .lost        (lost),
    .card_rdy    (card_rdy),
    .card_value  (card_value),
    .shoe_valid  (shoe_valid),
    .shoe_card   (shoe_card),
    .shoe_pop    (shoe_pop),
    .grant_id    (grant_id),
    .busy        (busy),
    .hands_won   (hands_won),
    .hands_lost  (hands_lost),
    .bad_cards   (bad_cards)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    #3;
    checks++;
    if ({card_rdy, card_value, grant_id, busy, shoe_pop,
         hands_won, hands_lost, bad_cards} !== '0) begin
      errs++;
      $display("FAIL reset_vals: rdy=%b val=%0d gid=%0d busy=%b pop=%b w=%0d l=%0d b=%0d want all 0",
               card_rdy, card_value, grant_id, busy, shoe_pop,
               hands_won, hands_lost, bad_cards);
    end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single;
    request_card = 4'b0001;
    shoe_valid   = 1'b1;
    shoe_card    = 4'd7;
    tick();
    checks++;
    if (busy !== 1'b1 || card_rdy !== 4'b0000) begin
      errs++;
      $display("FAIL single_fetch: busy=%b rdy=%b want 1/0000", busy, card_rdy);
    end
    checks++;
    if (shoe_pop !== 1'b1) begin
      errs++;
      $display("FAIL single_pop: got %b want 1", shoe_pop);
    end
    tick();
    checks++;
    if (card_rdy !== 4'b0001 || card_value !== 4'd7) begin
      errs++;
      $display("FAIL single_deal: rdy=%b val=%0d want 0001/7", card_rdy, card_value);
    end
    checks++;
    if (shoe_pop !== 1'b0) begin
      errs++;
      $display("FAIL single_pop_once: got %b want 0", shoe_pop);
    end
    request_card = 4'b0000;
    shoe_valid   = 1'b0;
    tick();
    checks++;
    if (card_rdy !== 4'b0000 || busy !== 1'b0) begin
      errs++;
      $display("FAIL single_release: rdy=%b busy=%b want 0000/0", card_rdy, busy);
    end
  endtask

  task automatic test_round_robin;
    int ord[6] = '{0, 1, 3, 0, 1, 3};
    pulse_reset();
    request_card = 4'b1011;
    shoe_valid   = 1'b1;
    for (int k = 0; k < 6; k++) begin
      shoe_card = 4'(k + 2);
      for (int c = 0; c < 8; c++) begin
        if (card_rdy != 4'b0000) break;
        tick();
      end
      checks++;
      if (card_rdy !== 4'(1 << ord[k]) || grant_id !== 3'(ord[k])) begin
        errs++;
        $display("FAIL rr_grant%0d: rdy=%b gid=%0d want gid %0d", k,
                 card_rdy, grant_id, ord[k]);
      end
      checks++;
      if (card_value !== 4'(k + 2)) begin
        errs++;
        $display("FAIL rr_value%0d: got %0d want %0d", k, card_value, k + 2);
      end
      request_card[ord[k]] = 1'b0;
      tick();
      checks++;
      if (card_rdy !== 4'b0000 || busy !== 1'b0) begin
        errs++;
        $display("FAIL rr_gap%0d: rdy=%b busy=%b want 0000/0", k, card_rdy, busy);
      end
      request_card = 4'b1011;
    end
    request_card = 4'b0000;
    shoe_valid   = 1'b0;
    tick();
  endtask

  task automatic test_bad_cards;
    int vals[3] = '{0, 15, 10};
    int pops = 0;
    request_card = 4'b0100;
    shoe_valid   = 1'b1;
    shoe_card    = 4'd0;
    tick();
    for (int k = 0; k < 3; k++) begin
      shoe_card = 4'(vals[k]);
      #1;
      if (shoe_pop === 1'b1) pops++;
      @(posedge clock);
      #1;
    end
    checks++;
    if (pops !== 3) begin
      errs++;
      $display("FAIL bad_pops: got %0d want 3", pops);
    end
    checks++;
    if (bad_cards !== 8'd2) begin
      errs++;
      $display("FAIL bad_count: got %0d want 2", bad_cards);
    end
    checks++;
    if (card_value !== 4'd10 || card_rdy !== 4'b0100 || grant_id !== 3'd2) begin
      errs++;
      $display("FAIL bad_deal: val=%0d rdy=%b gid=%0d want 10/0100/2",
               card_value, card_rdy, grant_id);
    end
    request_card = 4'b0000;
    shoe_valid   = 1'b0;
    tick();
    checks++;
    if (card_rdy !== 4'b0000) begin
      errs++;
      $display("FAIL bad_release: got %b want 0000", card_rdy);
    end
  endtask

  task automatic test_hand_end;
    shoe_valid   = 1'b1;
    shoe_card    = 4'd9;
    request_card = 4'b0100;
    win          = 4'b0100;
    tick();
    checks++;
    if (card_rdy !== 4'b0100 || grant_id !== 3'd2 || hands_won !== 8'd1) begin
      errs++;
      $display("FAIL win_ack: rdy=%b gid=%0d won=%0d want 0100/2/1",
               card_rdy, grant_id, hands_won);
    end
    checks++;
    if (shoe_pop !== 1'b0) begin
      errs++;
      $display("FAIL win_nopop: got %b want 0", shoe_pop);
    end
    tick();
    checks++;
    if (card_rdy !== 4'b0100 || hands_won !== 8'd1 || shoe_pop !== 1'b0) begin
      errs++;
      $display("FAIL win_hold: rdy=%b won=%0d pop=%b want 0100/1/0",
               card_rdy, hands_won, shoe_pop);
    end
    win = 4'b0000;
    tick();
    request_card = 4'b0000;
    checks++;
    if (card_rdy !== 4'b0000 || busy !== 1'b0) begin
      errs++;
      $display("FAIL win_release: rdy=%b busy=%b want 0000/0", card_rdy, busy);
    end
    tick();
    request_card = 4'b0100;
    win          = 4'b0100;
    lost         = 4'b0100;
    tick();
    checks++;
    if (card_rdy !== 4'b0100 || hands_lost !== 8'd1 || hands_won !== 8'd1) begin
      errs++;
      $display("FAIL lost_ack: rdy=%b lost=%0d won=%0d want 0100/1/1",
               card_rdy, hands_lost, hands_won);
    end
    win  = 4'b0000;
    lost = 4'b0000;
    tick();
    request_card = 4'b0000;
    shoe_valid   = 1'b0;
    checks++;
    if (card_rdy !== 4'b0000) begin
      errs++;
      $display("FAIL lost_release: got %b want 0000", card_rdy);
    end
    tick();
  endtask

  task automatic test_withdraw;
    request_card = 4'b0001;
    shoe_valid   = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b1 || grant_id !== 3'd0 || shoe_pop !== 1'b0) begin
      errs++;
      $display("FAIL wd_fetch: busy=%b gid=%0d pop=%b want 1/0/0",
               busy, grant_id, shoe_pop);
    end
    request_card = 4'b0000;
    shoe_valid   = 1'b1;
    shoe_card    = 4'd6;
    #1;
    checks++;
    if (shoe_pop !== 1'b0) begin
      errs++;
      $display("FAIL wd_priority: pop=%b want 0", shoe_pop);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || card_rdy !== 4'b0000 ||
        bad_cards !== 8'd2 || card_value !== 4'd10) begin
      errs++;
      $display("FAIL wd_idle: busy=%b rdy=%b bad=%0d val=%0d want 0/0000/2/10",
               busy, card_rdy, bad_cards, card_value);
    end
    shoe_valid = 1'b0;
  endtask

  task automatic test_reset_in_deal;
    request_card = 4'b0010;
    shoe_valid   = 1'b1;
    shoe_card    = 4'd5;
    tick();
    tick();
    checks++;
    if (card_rdy !== 4'b0010 || card_value !== 4'd5 || grant_id !== 3'd1) begin
      errs++;
      $display("FAIL rst_deal: rdy=%b val=%0d gid=%0d want 0010/5/1",
               card_rdy, card_value, grant_id);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({card_rdy, card_value, grant_id, busy, shoe_pop,
         hands_won, hands_lost, bad_cards} !== '0) begin
      errs++;
      $display("FAIL rst_async: rdy=%b val=%0d gid=%0d busy=%b pop=%b w=%0d l=%0d b=%0d want all 0",
               card_rdy, card_value, grant_id, busy, shoe_pop,
               hands_won, hands_lost, bad_cards);
    end
    request_card = 4'b0000;
    shoe_valid   = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_saturate;
    request_card = 4'b0001;
    for (int h = 0; h < 256; h++) begin
      win = 4'b0001;
      tick();
      win = 4'b0000;
      tick();
      if (h == 254) begin
        checks++;
        if (hands_won !== 8'd255) begin
          errs++;
          $display("FAIL sat_reach: got %0d want 255", hands_won);
        end
      end
    end
    request_card = 4'b0000;
    tick();
    checks++;
    if (hands_won !== 8'd255 || hands_lost !== 8'd0) begin
      errs++;
      $display("FAIL sat_hold: won=%0d lost=%0d want 255/0", hands_won, hands_lost);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_bad_cards();
    test_hand_end();
    test_withdraw();
    test_reset_in_deal();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule
